// File: rtl/cache_refill_ctrl_if.sv
// CPU, cache and RAM signal bundle for cache_refill_ctrl.
// The master modport is the controller side; slave is the CPU/cache/RAM environment.
interface cache_refill_ctrl_if #(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_BITS        = 32
);
    logic [RAM_ADDRESS_BITS-1:0] cpu_address;
    logic                        cpu_read_en;
    logic                        cpu_write_en;
    logic [DATA_BITS-1:0]        cpu_write_data;
    logic                        cpu_ready;
    logic [DATA_BITS-1:0]        cpu_read_data;
    logic                        cpu_valid;

    logic [RAM_ADDRESS_BITS-1:0] cache_address;
    logic                        cache_read_en;
    logic                        cache_write_en;
    logic [DATA_BITS-1:0]        cache_write_data;
    logic [DATA_BITS-1:0]        cache_read_data;
    logic                        cache_valid;
    logic                        cache_miss;

    logic [RAM_ADDRESS_BITS-1:0] ram_address;
    logic                        ram_read_en;
    logic [DATA_BITS-1:0]        ram_read_data;
    logic                        ram_read_valid;
    logic                        ram_write_en;
    logic [DATA_BITS-1:0]        ram_write_data;
    logic                        ram_ready;

    modport master (
        input  cpu_address, cpu_read_en, cpu_write_en, cpu_write_data,
        output cpu_ready, cpu_read_data, cpu_valid,
        output cache_address, cache_read_en, cache_write_en, cache_write_data,
        input  cache_read_data, cache_valid, cache_miss,
        output ram_address, ram_read_en, ram_write_en, ram_write_data,
        input  ram_read_data, ram_read_valid, ram_ready
    );

    modport slave (
        output cpu_address, cpu_read_en, cpu_write_en, cpu_write_data,
        input  cpu_ready, cpu_read_data, cpu_valid,
        input  cache_address, cache_read_en, cache_write_en, cache_write_data,
        output cache_read_data, cache_valid, cache_miss,
        input  ram_address, ram_read_en, ram_write_en, ram_write_data,
        output ram_read_data, ram_read_valid, ram_ready
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache refill sequencer: one CPU access at a time, block refill on read miss, write-through writes.
// Define CACHE_REFILL_CTRL_PERF_EN to add saturating perf_hits/perf_misses/perf_writes counters.
module cache_refill_ctrl #(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2
) (
    input  logic        clk,
    input  logic        reset,
`ifdef CACHE_REFILL_CTRL_PERF_EN
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses,
    output logic [31:0] perf_writes,
`endif
    cache_refill_ctrl_if.master bus
);

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_LOOKUP      = 4'd1;
    localparam logic [3:0] S_CHECK       = 4'd2;
    localparam logic [3:0] S_REFILL_REQ  = 4'd3;
    localparam logic [3:0] S_REFILL_WAIT = 4'd4;
    localparam logic [3:0] S_REPLAY      = 4'd5;
    localparam logic [3:0] S_WRITE       = 4'd6;
    localparam logic [3:0] S_WRITE_RAM   = 4'd7;
    localparam logic [3:0] S_RESPOND     = 4'd8;

    logic [3:0]                  state_q,     state_d;
    logic [RAM_ADDRESS_BITS-1:0] addr_q,      addr_d;
    logic [DATA_BITS-1:0]        writeData_q, writeData_d;
    logic [DATA_BITS-1:0]        readData_q,  readData_d;
    logic [BLOCK_BITS-1:0]       wordCount_q, wordCount_d;
    logic [RAM_ADDRESS_BITS-1:0] refillAddr;

    assign refillAddr = {addr_q[RAM_ADDRESS_BITS-1:BLOCK_BITS], wordCount_q};

    // Write wins over read when both are requested; the read is simply dropped.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        writeData_d = writeData_q;
        readData_d  = readData_q;
        wordCount_d = wordCount_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_write_en) begin
                    addr_d      = bus.cpu_address;
                    writeData_d = bus.cpu_write_data;
                    readData_d  = '0;
                    state_d     = S_WRITE;
                end else if (bus.cpu_read_en) begin
                    addr_d     = bus.cpu_address;
                    readData_d = '0;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP, S_REPLAY: state_d = S_CHECK;
            S_CHECK: begin
                if (bus.cache_valid) begin
                    readData_d = bus.cache_read_data;
                    state_d    = S_RESPOND;
                end else if (bus.cache_miss) begin
                    wordCount_d = '0;
                    state_d     = S_REFILL_REQ;
                end else begin
                    state_d = S_LOOKUP;
                end
            end
            S_REFILL_REQ: state_d = S_REFILL_WAIT;
            S_REFILL_WAIT: begin
                if (bus.ram_read_valid) begin
                    if (wordCount_q == '1) begin
                        state_d = S_REPLAY;
                    end else begin
                        wordCount_d = wordCount_q + 1'b1;
                        state_d     = S_REFILL_REQ;
                    end
                end
            end
            S_WRITE:     state_d = S_WRITE_RAM;
            S_WRITE_RAM: if (bus.ram_ready) state_d = S_RESPOND;
            S_RESPOND:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            writeData_q <= '0;
            readData_q  <= '0;
            wordCount_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            writeData_q <= writeData_d;
            readData_q  <= readData_d;
            wordCount_q <= wordCount_d;
        end
    end

    always_comb begin
        bus.cpu_ready        = 1'b0;
        bus.cpu_valid        = 1'b0;
        bus.cpu_read_data    = '0;
        bus.cache_address    = '0;
        bus.cache_read_en    = 1'b0;
        bus.cache_write_en   = 1'b0;
        bus.cache_write_data = '0;
        bus.ram_address      = '0;
        bus.ram_read_en      = 1'b0;
        bus.ram_write_en     = 1'b0;
        bus.ram_write_data   = '0;
        case (state_q)
            S_IDLE: bus.cpu_ready = 1'b1;
            S_LOOKUP, S_REPLAY: begin
                bus.cache_read_en = 1'b1;
                bus.cache_address = addr_q;
            end
            S_REFILL_REQ: begin
                bus.ram_read_en = 1'b1;
                bus.ram_address = refillAddr;
            end
            S_REFILL_WAIT: begin
                if (bus.ram_read_valid) begin
                    bus.cache_write_en   = 1'b1;
                    bus.cache_address    = refillAddr;
                    bus.cache_write_data = bus.ram_read_data;
                end
            end
            S_WRITE: begin
                bus.cache_write_en   = 1'b1;
                bus.cache_address    = addr_q;
                bus.cache_write_data = writeData_q;
            end
            S_WRITE_RAM: begin
                bus.ram_write_en   = 1'b1;
                bus.ram_address    = addr_q;
                bus.ram_write_data = writeData_q;
            end
            S_RESPOND: begin
                bus.cpu_valid     = 1'b1;
                bus.cpu_read_data = readData_q;
            end
            default: ;
        endcase
    end

`ifdef CACHE_REFILL_CTRL_PERF_EN
    logic replay_q;

    // A hit seen in the CHECK after a replay is the tail of a miss, so it is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            replay_q    <= 1'b0;
            perf_hits   <= '0;
            perf_misses <= '0;
            perf_writes <= '0;
        end else begin
            if (state_q == S_REPLAY) replay_q <= 1'b1;
            else if (state_q == S_IDLE) replay_q <= 1'b0;
            if (state_q == S_CHECK && bus.cache_valid && !replay_q && perf_hits != '1)
                perf_hits <= perf_hits + 1'b1;
            if (state_q == S_CHECK && !bus.cache_valid && bus.cache_miss && perf_misses != '1)
                perf_misses <= perf_misses + 1'b1;
            if (state_q == S_WRITE && perf_writes != '1)
                perf_writes <= perf_writes + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: cache/RAM responders, a transaction-level model
// and a per-cycle compare process, driven by directed read/write vectors.
module tb_cache_refill_ctrl;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int BB    = 2;
    localparam int BLOCK = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cache_refill_ctrl_if #(.RAM_ADDRESS_BITS(AW), .DATA_BITS(DW)) bus ();

`ifdef CACHE_REFILL_CTRL_PERF_EN
    logic [31:0] perfHits, perfMisses, perfWrites;
`endif

    cache_refill_ctrl #(.RAM_ADDRESS_BITS(AW), .DATA_BITS(DW), .BLOCK_BITS(BB)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef CACHE_REFILL_CTRL_PERF_EN
        .perf_hits   (perfHits),
        .perf_misses (perfMisses),
        .perf_writes (perfWrites),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    bit rstSampled = 1'b1;

    logic [31:0] ramMem    [0:1023];
    logic [31:0] cacheData [0:1023];
    bit          cacheValid[0:1023];
    int ramLatency = 1;
    int readyDelay = 0;

    bit          active = 1'b0;
    bit          expWrite;
    logic [9:0]  expAddr;
    logic [31:0] expWData, expRData;
    int          acceptCycle, expLatency;
    int          nCacheRd, nCacheWr, nRamRd, nRamWrCycles;
    logic [9:0]  lastRamAddr;
    logic [9:0]  ramRdLog[$];
    logic [31:0] lastCpuData;
    int          lastValidCycle;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cycleCount++;
        rstSampled = reset;
        if (reset) active = 1'b0;
    end

    // Registered cache (answers one cycle after a lookup) and RAM with programmable latencies.
    initial begin
        bit         capCacheRd, capRamRd, capRamWr, capRamRdy;
        logic [9:0] capCacheAddr, capRamAddr, pendAddr;
        int         pending, wrSeen;
        pending = 0;
        wrSeen  = 0;
        bus.cache_valid = 1'b0; bus.cache_miss = 1'b0; bus.cache_read_data = '0;
        bus.ram_read_valid = 1'b0; bus.ram_read_data = '0; bus.ram_ready = 1'b0;
        forever begin
            @(negedge clk);
            capCacheRd   = bus.cache_read_en;
            capCacheAddr = bus.cache_address;
            capRamRd     = bus.ram_read_en;
            capRamAddr   = bus.ram_address;
            capRamWr     = bus.ram_write_en;
            capRamRdy    = bus.ram_ready;
            if (bus.cache_write_en) begin
                cacheData[bus.cache_address]  = bus.cache_write_data;
                cacheValid[bus.cache_address] = 1'b1;
            end
            if (capRamWr && capRamRdy) ramMem[bus.ram_address] = bus.ram_write_data;
            @(posedge clk);
            #1;
            bus.cache_valid     = capCacheRd && cacheValid[capCacheAddr];
            bus.cache_miss      = capCacheRd && !cacheValid[capCacheAddr];
            bus.cache_read_data = bus.cache_valid ? cacheData[capCacheAddr] : '0;
            bus.ram_read_valid  = 1'b0;
            bus.ram_read_data   = '0;
            if (capRamRd) begin
                pending  = ramLatency;
                pendAddr = capRamAddr;
            end
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    bus.ram_read_valid = 1'b1;
                    bus.ram_read_data  = ramMem[pendAddr];
                end
            end
            wrSeen = capRamWr ? wrSeen + 1 : 0;
            bus.ram_ready = (wrSeen == readyDelay);
        end
    end

    // Compare process: the DUT is busy from the cycle after acceptance through the cpu_valid cycle.
    initial begin
        bit busy;
        logic [4:0] strobes;
        forever begin
            @(negedge clk);
            strobes = {bus.cpu_valid, bus.cache_read_en, bus.cache_write_en, bus.ram_read_en, bus.ram_write_en};
            if (rstSampled) begin
                checkOutput("reset cpu_ready", 32'(bus.cpu_ready), 32'd1);
                checkOutput("reset strobes", 32'(strobes), 32'd0);
                checkOutput("reset addresses", 32'({bus.cache_address, bus.ram_address}), 32'd0);
                checkOutput("reset data outputs", bus.cpu_read_data | bus.cache_write_data | bus.ram_write_data, 32'd0);
            end else begin
                busy = active && cycleCount > acceptCycle && cycleCount <= acceptCycle + expLatency;
                if (!busy) begin
                    checkOutput("idle cpu_ready", 32'(bus.cpu_ready), 32'd1);
                    checkOutput("idle strobes", 32'(strobes), 32'd0);
                end else begin
                    checkOutput("busy cpu_ready", 32'(bus.cpu_ready), 32'd0);
                    checkOutput("strobe exclusive",
                                32'($countones({bus.cache_read_en, bus.cache_write_en, bus.ram_read_en}) <= 1), 32'd1);
                    checkOutput("cpu_valid timing", 32'(bus.cpu_valid), 32'(cycleCount == acceptCycle + expLatency));
                    if (bus.cpu_valid) begin
                        checkOutput("cpu_read_data", bus.cpu_read_data, expRData);
                        lastCpuData    = bus.cpu_read_data;
                        lastValidCycle = cycleCount;
                    end
                    if (bus.cache_read_en) begin
                        nCacheRd++;
                        checkOutput("lookup address", 32'(bus.cache_address), 32'(expAddr));
                    end
                    if (bus.cache_write_en) begin
                        nCacheWr++;
                        if (expWrite) begin
                            checkOutput("cache write address", 32'(bus.cache_address), 32'(expAddr));
                            checkOutput("cache write data", bus.cache_write_data, expWData);
                        end else begin
                            checkOutput("refill write address", 32'(bus.cache_address), 32'(lastRamAddr));
                            checkOutput("refill write data", bus.cache_write_data, ramMem[lastRamAddr]);
                        end
                    end
                    if (bus.ram_read_en) begin
                        checkOutput("ram read address", 32'(bus.ram_address),
                                    32'((int'(expAddr) / BLOCK) * BLOCK + nRamRd % BLOCK));
                        lastRamAddr = bus.ram_address;
                        ramRdLog.push_back(bus.ram_address);
                        nRamRd++;
                    end
                    if (bus.ram_write_en) begin
                        nRamWrCycles++;
                        checkOutput("ram write address", 32'(bus.ram_address), 32'(expAddr));
                        checkOutput("ram write data", bus.ram_write_data, expWData);
                    end
                    if (cycleCount == acceptCycle + expLatency) active = 1'b0;
                end
            end
        end
    end

    // The accept cycle counts as cycle 1, so a hit returns three clock edges after acceptance.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [9:0] addr, input logic [31:0] data,
                                 input int lat, input int rdy, input bit stray, input bit waitDone);
        @(posedge clk);
        #1;
        ramLatency = lat;
        readyDelay = rdy;
        expWrite   = wr;
        expAddr    = addr;
        expWData   = data;
        if (wr) begin
            expRData   = '0;
            expLatency = 3 + rdy;
        end else if (cacheValid[addr]) begin
            expRData   = cacheData[addr];
            expLatency = 3;
        end else begin
            expRData   = ramMem[addr];
            expLatency = 2 + BLOCK * (1 + lat) + 3;
        end
        nCacheRd = 0; nCacheWr = 0; nRamRd = 0; nRamWrCycles = 0;
        ramRdLog.delete();
        acceptCycle = cycleCount;
        active      = 1'b1;
        bus.cpu_read_en    = rd;
        bus.cpu_write_en   = wr;
        bus.cpu_address    = addr;
        bus.cpu_write_data = data;
        @(posedge clk);
        #1;
        bus.cpu_read_en  = 1'b0;
        bus.cpu_write_en = 1'b0;
        if (stray) begin
            @(posedge clk);
            #1;
            bus.cpu_read_en = 1'b1;
            bus.cpu_address = 10'h3FF;
            @(posedge clk);
            #1;
            bus.cpu_read_en = 1'b0;
        end
        if (waitDone) begin
            for (int i = 0; i < 200 && active; i++) @(posedge clk);
            checkOutput("transaction timeout", 32'(active), 32'd0);
            active = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.cpu_read_en = 1'b0; bus.cpu_write_en = 1'b0;
        bus.cpu_address = '0;   bus.cpu_write_data = '0;
        for (int i = 0; i < 1024; i++) begin
            ramMem[i]     = 32'h5000_0000 + 32'(i);
            cacheData[i]  = '0;
            cacheValid[i] = 1'b0;
        end
        for (int i = 0; i < BLOCK; i++) begin
            ramMem[10'h010 + i] = 32'hA0 + 32'(i);
            ramMem[10'h040 + i] = 32'hB0 + 32'(i);
        end
        cacheValid[10'h010] = 1'b1;
        cacheData[10'h010]  = 32'hDEADBEEF;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t1 idle after reset", 32'(bus.cpu_ready), 32'd1);

        applyStimulus(1'b1, 1'b0, 10'h010, 32'h0, 1, 0, 1'b0, 1'b1);
        checkOutput("t2 read data", lastCpuData, 32'hDEADBEEF);
        checkOutput("t2 latency", 32'(lastValidCycle - acceptCycle), 32'd3);
        checkOutput("t2 lookups", 32'(nCacheRd), 32'd1);

        applyStimulus(1'b1, 1'b0, 10'h013, 32'h0, 3, 0, 1'b0, 1'b1);
        checkOutput("t3 read data", lastCpuData, 32'hA3);
        checkOutput("t3 latency", 32'(lastValidCycle - acceptCycle), 32'd21);
        checkOutput("t3 cache writes", 32'(nCacheWr), 32'd4);
        checkOutput("t3 lookups", 32'(nCacheRd), 32'd2);
        checkOutput("t3 ram reads", 32'(ramRdLog.size()), 32'd4);
        for (int i = 0; i < ramRdLog.size() && i < BLOCK; i++)
            checkOutput("t3 ram read order", 32'(ramRdLog[i]), 32'h010 + 32'(i));

        applyStimulus(1'b0, 1'b1, 10'h020, 32'h12345678, 1, 5, 1'b0, 1'b1);
        checkOutput("t4 cache writes", 32'(nCacheWr), 32'd1);
        checkOutput("t4 ram_write_en cycles", 32'(nRamWrCycles), 32'd6);
        checkOutput("t4 ram contents", ramMem[10'h020], 32'h12345678);
        checkOutput("t4 write response data", lastCpuData, 32'd0);
        checkOutput("t4 latency", 32'(lastValidCycle - acceptCycle), 32'd8);
`ifdef CACHE_REFILL_CTRL_PERF_EN
        checkOutput("perf hits", perfHits, 32'd1);
        checkOutput("perf misses", perfMisses, 32'd1);
        checkOutput("perf writes", perfWrites, 32'd1);
`endif

        applyStimulus(1'b1, 1'b1, 10'h030, 32'hCAFEF00D, 1, 2, 1'b1, 1'b1);
        checkOutput("t5 lookups", 32'(nCacheRd), 32'd0);
        checkOutput("t5 cache writes", 32'(nCacheWr), 32'd1);
        checkOutput("t5 ram_write_en cycles", 32'(nRamWrCycles), 32'd3);
        checkOutput("t5 ram contents", ramMem[10'h030], 32'hCAFEF00D);

        applyStimulus(1'b1, 1'b0, 10'h041, 32'h0, 3, 0, 1'b0, 1'b0);
        for (int i = 0; i < 100 && nRamRd < 3; i++) @(negedge clk);
        checkOutput("t6 third refill read", 32'(nRamRd), 32'd3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t6 cache writes before reset", 32'(nCacheWr), 32'd2);
        checkOutput("t6 no late cache write", 32'(cacheValid[10'h042]), 32'd0);
        checkOutput("t6 idle after reset", 32'(bus.cpu_ready), 32'd1);
`ifdef CACHE_REFILL_CTRL_PERF_EN
        checkOutput("perf hits cleared", perfHits, 32'd0);
        checkOutput("perf misses cleared", perfMisses, 32'd0);
        checkOutput("perf writes cleared", perfWrites, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
